// File: rtl/sobel_edge_param.sv
// Parametrised 3x3 Sobel edge detector on a raster pixel stream.
// Two line buffers feed a 3x3 window, followed by a three-stage gradient pipeline.
module sobel_edge_param #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 160,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic [DATA_W+2:0] thresh,
    input  logic              mode,
    output logic [DATA_W+2:0] dout_mag,
    output logic              dout_edge,
    output logic              dout_valid,
    output logic              dout_sof,
    output logic              dout_eol
);

    localparam int SW = DATA_W + 2;
    localparam int MW = DATA_W + 3;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];
    logic [CNT_W-1:0]  col, row;
    logic [DATA_W-1:0] top, mid;
    logic [DATA_W-1:0] w11, w12, w13, w21, w22, w23, w31, w32, w33;
    logic [MW-1:0]     cfg_thresh;
    logic              cfg_mode;
    logic              v0, sof0, eol0, mode0;
    logic [MW-1:0]     thr0;
    logic              v1, sof1, eol1, mode1;
    logic [MW-1:0]     thr1;
    logic              v2, sof2, eol2, mode2;
    logic [MW-1:0]     thr2;
    logic [SW-1:0]     sum_l, sum_r, sum_t, sum_b;
    logic [SW-1:0]     gx, gy;
    logic [MW-1:0]     mag_next;

    // Old line-buffer contents are read before being overwritten.
    assign top = lb2[col];
    assign mid = lb1[col];

    // Column/row position of the next accepted pixel.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            col <= '0;
            row <= '0;
        end else if (din_valid) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= (row == LAST_ROW) ? '0 : row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

    // Line buffers hold rows r-1 and r-2; contents are never cleared.
    always_ff @(posedge clk) begin
        if (din_valid) begin
            lb2[col] <= lb1[col];
            lb1[col] <= din;
        end
    end

    // Window shift, per-frame config latch and first-stage tags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            {w11, w12, w13, w21, w22, w23, w31, w32, w33} <= '0;
            cfg_thresh <= '0;
            cfg_mode   <= 1'b0;
            v0    <= 1'b0;
            sof0  <= 1'b0;
            eol0  <= 1'b0;
            mode0 <= 1'b0;
            thr0  <= '0;
        end else begin
            v0    <= din_valid && row >= TWO && col >= TWO;
            sof0  <= din_valid && row == TWO && col == TWO;
            eol0  <= din_valid && row >= TWO && col == LAST_COL;
            mode0 <= cfg_mode;
            thr0  <= cfg_thresh;
            if (din_valid) begin
                w11 <= w12; w12 <= w13; w13 <= top;
                w21 <= w22; w22 <= w23; w23 <= mid;
                w31 <= w32; w32 <= w33; w33 <= din;
                if (row == '0 && col == '0) begin
                    cfg_thresh <= thresh;
                    cfg_mode   <= mode;
                end
            end
        end
    end

    // S1: weighted column and row sums.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            {sum_l, sum_r, sum_t, sum_b} <= '0;
            {v1, sof1, eol1, mode1} <= '0;
            thr1 <= '0;
        end else begin
            sum_l <= SW'(w11) + (SW'(w21) << 1) + SW'(w31);
            sum_r <= SW'(w13) + (SW'(w23) << 1) + SW'(w33);
            sum_t <= SW'(w11) + (SW'(w12) << 1) + SW'(w13);
            sum_b <= SW'(w31) + (SW'(w32) << 1) + SW'(w33);
            {v1, sof1, eol1, mode1} <= {v0, sof0, eol0, mode0};
            thr1 <= thr0;
        end
    end

    // S2: unsigned absolute gradients.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            {gx, gy} <= '0;
            {v2, sof2, eol2, mode2} <= '0;
            thr2 <= '0;
        end else begin
            gx <= (sum_l >= sum_r) ? sum_l - sum_r : sum_r - sum_l;
            gy <= (sum_t >= sum_b) ? sum_t - sum_b : sum_b - sum_t;
            {v2, sof2, eol2, mode2} <= {v1, sof1, eol1, mode1};
            thr2 <= thr1;
        end
    end

    // Magnitude: sum of gradients or the larger one.
    always_comb begin
        mag_next = MW'(gx) + MW'(gy);
        if (mode2)
            mag_next = (gx >= gy) ? MW'(gx) : MW'(gy);
    end

    // S3: output registers; data holds between valid strobes.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout_mag   <= '0;
            dout_edge  <= 1'b0;
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
            dout_eol   <= 1'b0;
        end else begin
            dout_valid <= v2;
            dout_sof   <= v2 & sof2;
            dout_eol   <= v2 & eol2;
            if (v2) begin
                dout_mag  <= mag_next;
                dout_edge <= mag_next > thr2;
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge_param.sv
// Directed bench for sobel_edge_param at 8x6, 8-bit pixels.
// Expected outputs come from hand-derived per-pattern formulas.
module tb_sobel_edge_param;

    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 6;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] din;
    logic          din_valid;
    logic [DW+2:0] thresh;
    logic          mode;
    logic [DW+2:0] dout_mag;
    logic          dout_edge;
    logic          dout_valid;
    logic          dout_sof;
    logic          dout_eol;

    sobel_edge_param #(
        .DATA_W(DW), .IMG_W(W), .IMG_H(H), .CNT_W(3)
    ) dut (
        .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid),
        .thresh(thresh), .mode(mode), .dout_mag(dout_mag),
        .dout_edge(dout_edge), .dout_valid(dout_valid),
        .dout_sof(dout_sof), .dout_eol(dout_eol)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int mag;
        int edg;
        int sof;
        int eol;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int out_cnt = 0;
    int sof_cnt = 0;
    int eol_cnt = 0;
    int last_mag = 0;
    int last_edge = 0;
    bit in_reset = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int pix(input int scen, input int r, input int c);
        case (scen)
            1: return 100;
            2: return (c >= 4) ? 255 : 0;
            default: return (r == 2 && c == 2) ? 255 : 0;
        endcase
    endfunction

    // Expected magnitude for the output of accepted pixel (r,c), centre (r-1,c-1).
    function automatic int exp_mag(input int scen, input int m, input int r, input int c);
        int cr, cc, dr, dc, i, j, gx, gy;
        cr = r - 1;
        cc = c - 1;
        if (scen == 1) return 0;
        if (scen == 2) return (cc == 3 || cc == 4) ? 1020 : 0;
        dr = 2 - cr;
        dc = 2 - cc;
        if (dr > 1 || dr < -1 || dc > 1 || dc < -1) return 0;
        i = dr + 2;
        j = dc + 2;
        gx = (j != 2) ? ((i == 2) ? 510 : 255) : 0;
        gy = (i != 2) ? ((j == 2) ? 510 : 255) : 0;
        if (m == 1) return (gx > gy) ? gx : gy;
        return gx + gy;
    endfunction

    task automatic send_frame(input int scen, input int m, input int thr,
                              input int gap, input int chg_at, input int chg_val,
                              input int npix, input bit push);
        exp_t e;
        int r, c, mg;
        mode = m[0];
        for (int idx = 0; idx < npix; idx++) begin
            r = idx / W;
            c = idx % W;
            while (gap > 0 && $urandom_range(99) < gap) begin
                @(negedge clk);
                din_valid = 1'b0;
            end
            @(negedge clk);
            din = DW'(pix(scen, r, c));
            din_valid = 1'b1;
            if (idx == chg_at) thresh = 11'(chg_val);
            if (push && r >= 2 && c >= 2) begin
                mg = exp_mag(scen, m, r, c);
                e.t = cyc + 4;
                e.mag = mg;
                e.edg = (mg > thr) ? 1 : 0;
                e.sof = (r == 2 && c == 2) ? 1 : 0;
                e.eol = (c == W - 1) ? 1 : 0;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid = 1'b0;
        end
    endtask

    // Output monitor: compares each strobe with the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!in_reset) begin
            if (dout_valid) begin
                out_cnt++;
                sof_cnt += int'(dout_sof);
                eol_cnt += int'(dout_eol);
                if (q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("mag", int'(dout_mag), e.mag);
                    chk("edge", int'(dout_edge), e.edg);
                    chk("sof", int'(dout_sof), e.sof);
                    chk("eol", int'(dout_eol), e.eol);
                    chk("latency", cyc, e.t);
                end
            end else begin
                chk("idle_flags", int'({dout_sof, dout_eol}), 0);
                chk("hold_mag", int'(dout_mag), last_mag);
                chk("hold_edge", int'(dout_edge), last_edge);
            end
        end
        last_mag = int'(dout_mag);
        last_edge = int'(dout_edge);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        din = '0;
        din_valid = 1'b0;
        thresh = 11'd150;
        mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", int'(dout_valid), 0);
        chk("reset_mag", int'(dout_mag), 0);
        chk("reset_edge", int'(dout_edge), 0);
        chk("reset_flags", int'({dout_sof, dout_eol}), 0);
        rstn = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;

        // Flat frame
        out_cnt = 0; sof_cnt = 0; eol_cnt = 0;
        send_frame(1, 0, 150, 0, -1, 0, W * H, 1'b1);
        idle(6);
        chk("flat_count", out_cnt, 24);
        chk("flat_sof_count", sof_cnt, 1);
        chk("flat_eol_count", eol_cnt, 4);

        // Vertical step, continuous
        out_cnt = 0;
        send_frame(2, 0, 150, 0, -1, 0, W * H, 1'b1);
        idle(6);
        chk("step_count", out_cnt, 24);

        // Impulse: mode 0 then mode 1, back to back
        thresh = 11'd300;
        send_frame(3, 0, 300, 0, -1, 0, W * H, 1'b1);
        send_frame(3, 1, 300, 0, -1, 0, W * H, 1'b1);
        idle(6);

        // Vertical step with random valid gaps
        thresh = 11'd150;
        out_cnt = 0;
        send_frame(2, 0, 150, 50, -1, 0, W * H, 1'b1);
        idle(6);
        chk("gap_count", out_cnt, 24);

        // Threshold change mid-frame applies from the next frame
        send_frame(2, 0, 150, 0, 20, 2000, W * H, 1'b1);
        send_frame(2, 0, 2000, 0, -1, 0, W * H, 1'b1);
        idle(6);

        // Reset after 20 pixels, then a clean frame
        thresh = 11'd150;
        send_frame(2, 0, 150, 0, -1, 0, 20, 1'b0);
        @(negedge clk);
        din_valid = 1'b0;
        rstn = 1'b0;
        in_reset = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        chk("midrst_valid", int'(dout_valid), 0);
        chk("midrst_mag", int'(dout_mag), 0);
        chk("midrst_edge", int'(dout_edge), 0);
        chk("midrst_flags", int'({dout_sof, dout_eol}), 0);
        @(negedge clk);
        in_reset = 1'b0;
        out_cnt = 0; sof_cnt = 0; eol_cnt = 0;
        send_frame(2, 0, 150, 0, -1, 0, W * H, 1'b1);
        idle(6);
        chk("post_rst_count", out_cnt, 24);
        chk("post_rst_sof", sof_cnt, 1);
        chk("post_rst_eol", eol_cnt, 4);

        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_edge_param.md
Name: sobel_edge_param

Overview:
- Parametrised 3x3 Sobel edge detector. Successor to the fixed 8-bit, 160x160 edge block.
- Accepts a raster grey-scale pixel stream qualified by a valid strobe. Pixel width, image size, threshold and magnitude mode are all configurable.
- Emits a per-pixel gradient magnitude and an edge bit for every interior pixel, tagged with frame and line markers.
- Sits between the grey-scale converter and the display/frame-buffer writer.

Parameters:
- DATA_W, 8: input pixel width in bits.
- IMG_W, 160: pixels per line. Must be at least 3.
- IMG_H, 160: lines per frame. Must be at least 3.
- CNT_W, 8: column/row counter width. Must satisfy 2^CNT_W >= max(IMG_W, IMG_H).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  synchronous active-low reset.
- din  in  DATA_W  pixel, raster order.
- din_valid  in  1  pixel accepted on any rising edge where high. Gaps are allowed anywhere.
- thresh  in  DATA_W+3  edge threshold.
- mode  in  1  0 = |Gx|+|Gy|; 1 = max(|Gx|,|Gy|).
- dout_mag  out  DATA_W+3  gradient magnitude.
- dout_edge  out  1  1 when dout_mag > threshold.
- dout_valid  out  1  one-cycle strobe per interior output.
- dout_sof  out  1  with dout_valid: first interior output of a frame.
- dout_eol  out  1  with dout_valid: last interior output of a line.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is synchronous and active-low.
- While rstn is low at a rising edge, the following clear to 0: col/row counters, window registers, pipeline valid tags, dout_mag, dout_edge, dout_valid, dout_sof, dout_eol.
- Line-buffer contents need not clear. Stale data is never emitted because rows 0-1 are suppressed.
- Reset mid-frame: the next accepted pixel is treated as (row 0, col 0).
- Counters advance only on accepted pixels.
  - col wraps IMG_W-1 -> 0 and increments row.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0.
- Line buffers: two internal buffers of IMG_W x DATA_W, holding rows r-1 and r-2, indexed by col.
  - Read and write happen in the same accepted cycle, old data read first.
- Window: 3x3 registers shift left by one column on each accepted pixel.
  - New right column = {row r-2, row r-1, din}.
  - Window is held when din_valid is low.
- Config sampling: thresh and mode are latched when pixel (0,0) is accepted and stay constant for that frame.
  - After reset, the latched values are also loaded from the ports on the first accepted pixel.
- Pipeline: free-running, each stage carrying a valid tag.
  - S1: column sums and row sums, each width DATA_W+2:
    - L = w11 + 2·w21 + w31
    - R = w13 + 2·w23 + w33
    - T = w11 + 2·w12 + w13
    - B = w31 + 2·w32 + w33
  - S2: |Gx| = |L-R| and |Gy| = |T-B|, unsigned absolute difference.
  - S3 (output registers):
    - mode 0: dout_mag = |Gx|+|Gy|, width DATA_W+3, no saturation.
    - mode 1: dout_mag = max of the two, zero-extended.
    - dout_edge = (dout_mag > latched thresh), strict greater-than.
- Latency: outputs for the pixel accepted at edge k appear registered after edge k+3. Throughput is one pixel per cycle.
- Validity: the output for the pixel accepted at (r,c) is valid only if r >= 2 and c >= 2. That output is the window centred on (r-1, c-1).
- Output counts per frame:
  - Exactly (IMG_W-2)·(IMG_H-2) dout_valid pulses.
  - dout_sof: the output for accepted pixel (2,2).
  - dout_eol: the output for accepted pixel (r, IMG_W-1).
- When dout_valid is low: dout_sof and dout_eol are 0, while dout_mag and dout_edge hold their last values.
- Back-to-back frames: there is no bubble required between the last pixel of one frame and the first of the next.

Test Plan:
All scenarios use IMG_W=8, IMG_H=6, DATA_W=8.
1. Flat frame, all pixels 100, thresh=150, continuous valid -> 24 dout_valid pulses, all dout_mag=0, dout_edge=0; exactly one sof; exactly 4 eol.
2. Vertical step, cols 0-3 = 0 and cols 4-7 = 255, mode 0, thresh=150 -> per interior line (centres 1..6) dout_mag = 0,0,1020,1020,0,0 and dout_edge = 0,0,1,1,0,0.
3. Single pixel 255 at (2,2), rest 0, thresh=300 -> centre (1,1) gives mode 0: mag 510, edge 1; mode 1 (next frame): mag 255, edge 0.
4. Scenario 2 repeated with random din_valid gaps (30-70% duty) -> identical dout sequence to scenario 2; each output exactly 3 cycles after its accepting edge.
5. Change thresh from 150 to 2000 mid-frame -> no effect until the next frame; next frame's step edges have dout_edge=0.
6. rstn low for one cycle after 20 accepted pixels, then full clean frame -> all outputs 0 during reset; subsequent frame matches scenario 2 exactly; no spurious dout_valid before accepted pixel (2,2).
